// File: rtl/req_gnt_arbiter_pkg.sv
// Shared types, limits and the rotation helper for the round-robin req/gnt arbiter.
package req_gnt_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int REQ_GNT_MAX_N    = 16;
    localparam int REQ_GNT_MAX_HOLD = 255;

    // Index that follows idx in a ring of n requesters.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        if ((idx + 32'd1) >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/req_gnt_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface req_gnt_arbiter_if #(
    parameter int N = 4
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            preempt;

    modport master (output req, input gnt, input gnt_valid, input gnt_id, input preempt);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id, output preempt);
endinterface

// File: rtl/req_gnt_arbiter_chk.sv
// Protocol checker for req_gnt_arbiter; compiled only with REQ_GNT_ARBITER_ASSERT_EN.
`ifdef REQ_GNT_ARBITER_ASSERT_EN
module req_gnt_arbiter_chk #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int HW       = 4
) (
    input logic          clk,
    input logic          rst,
    input logic [N-1:0]  req,
    input logic [N-1:0]  gnt,
    input logic          gnt_valid,
    input logic          preempt,
    input logic [HW-1:0] hold_cnt,
    input logic          idle
);

    a_onehot_gnt: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_had_req: assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> ((gnt & ~$past(req)) == {N{1'b0}}));
    a_idle_single: assert property (@(posedge clk) disable iff (rst)
        (idle && $onehot(req)) |=> (gnt == $past(req)));
    a_hold_bound: assert property (@(posedge clk) disable iff (rst) 32'(hold_cnt) <= MAX_HOLD);
    a_preempt_valid: assert property (@(posedge clk) disable iff (rst) preempt |-> gnt_valid);
    c_preempt: cover property (@(posedge clk) disable iff (rst) preempt);

endmodule
`endif

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first request at or after start, skipping excl.
module rr_pick
    import req_gnt_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic [N-1:0] excl,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk the ring once from start and latch the first eligible requester.
    always_comb begin
        int unsigned cur;
        logic [W-1:0] cand;
        found = 1'b0;
        idx   = {W{1'b0}};
        cur   = 32'(start);
        for (int i = 0; i < N; i++) begin
            cand = W'(cur);
            if (!found && req[cand] && !excl[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                idx = idx;
            end
            cur = rr_next_idx(cur, N);
        end
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold-limit preemption.
// Define REQ_GNT_ARBITER_ASSERT_EN to bind in the protocol checker.
module req_gnt_arbiter
    import req_gnt_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst,
    req_gnt_arbiter_if.slave bus
);

    localparam int W  = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

    arb_state_t    state_r, state_nx_s;
    logic [W-1:0]  owner_r, owner_nx_s, last_id_r, last_id_nx_s;
    logic [W-1:0]  gnt_id_r, gnt_id_nx_s, pick_idx_s, start_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_nx_s;
    logic [N-1:0]  gnt_r, gnt_nx_s, owner_mask_s, excl_s;
    logic          gnt_valid_r, preempt_r, preempt_nx_s;
    logic          pick_found_s, owner_req_s, others_s;

    // last_id equals the owner while granting, so one start index serves every path.
    assign owner_mask_s = N'(1) << owner_r;
    assign excl_s       = (state_r == GRANT) ? owner_mask_s : {N{1'b0}};
    assign start_s      = W'(rr_next_idx(32'(last_id_r), N));
    assign owner_req_s  = |(bus.req & owner_mask_s);
    assign others_s     = |(bus.req & ~owner_mask_s);

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .start (start_s),
        .excl  (excl_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nx_s    = state_r;
        owner_nx_s    = owner_r;
        last_id_nx_s  = last_id_r;
        hold_cnt_nx_s = hold_cnt_r;
        gnt_nx_s      = gnt_r;
        gnt_id_nx_s   = gnt_id_r;
        preempt_nx_s  = 1'b0;
        case (state_r)
            IDLE, GRANT: begin
                if ((state_r == IDLE) || !owner_req_s || (others_s && (hold_cnt_r == MAX_HOLD_C))) begin
                    // Fresh arbitration: from idle, after a release, or on hold expiry.
                    if (pick_found_s) begin
                        state_nx_s    = GRANT;
                        owner_nx_s    = pick_idx_s;
                        last_id_nx_s  = pick_idx_s;
                        hold_cnt_nx_s = HW'(1);
                        gnt_nx_s      = N'(1) << pick_idx_s;
                        gnt_id_nx_s   = pick_idx_s;
                        preempt_nx_s  = (state_r == GRANT) && owner_req_s;
                    end else begin
                        state_nx_s    = IDLE;
                        hold_cnt_nx_s = {HW{1'b0}};
                        gnt_nx_s      = {N{1'b0}};
                        gnt_id_nx_s   = {W{1'b0}};
                    end
                end else begin
                    gnt_nx_s      = owner_mask_s;
                    gnt_id_nx_s   = owner_r;
                    hold_cnt_nx_s = (hold_cnt_r < MAX_HOLD_C) ? (hold_cnt_r + HW'(1)) : MAX_HOLD_C;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                hold_cnt_nx_s = {HW{1'b0}};
                gnt_nx_s      = {N{1'b0}};
                gnt_id_nx_s   = {W{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_r     <= {W{1'b0}};
            last_id_r   <= W'(N - 1);
            hold_cnt_r  <= {HW{1'b0}};
            gnt_r       <= {N{1'b0}};
            gnt_id_r    <= {W{1'b0}};
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            owner_r     <= owner_nx_s;
            last_id_r   <= last_id_nx_s;
            hold_cnt_r  <= hold_cnt_nx_s;
            gnt_r       <= gnt_nx_s;
            gnt_id_r    <= gnt_id_nx_s;
            gnt_valid_r <= |gnt_nx_s;
            preempt_r   <= preempt_nx_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.preempt   = preempt_r;

`ifdef REQ_GNT_ARBITER_ASSERT_EN
    req_gnt_arbiter_chk #(.N(N), .MAX_HOLD(MAX_HOLD), .HW(HW)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .gnt       (gnt_r),
        .gnt_valid (gnt_valid_r),
        .preempt   (preempt_r),
        .hold_cnt  (hold_cnt_r),
        .idle      (state_r == IDLE)
    );
`endif

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed self-checking bench for req_gnt_arbiter (N=4, MAX_HOLD=2).
module tb_req_gnt_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    req_gnt_arbiter_if #(.N(4)) bus ();

    req_gnt_arbiter #(.N(4), .MAX_HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs driven after this are safe from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.gnt_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", bus.gnt_id); end
        n_cmp++; if (bus.preempt !== 1'b0) begin n_bad++; $display("FAIL reset_preempt: got %b want 0", bus.preempt); end
        n_cmp++; if (dut.hold_cnt_r !== 2'd0) begin n_bad++; $display("FAIL reset_hold: got %0d want 0", dut.hold_cnt_r); end
        tick();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_no_req: got %b want 0000", bus.gnt); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
        n_cmp++; if (bus.gnt_id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", bus.gnt_id); end
        n_cmp++; if (bus.gnt_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.gnt_valid); end
        n_cmp++; if (bus.preempt !== 1'b0) begin n_bad++; $display("FAIL single_preempt: got %b want 0", bus.preempt); end
        bus.req = 4'b0000;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL single_release: got %b want 0000", bus.gnt); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_bad++; $display("FAIL single_release_valid: got %b want 0", bus.gnt_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_owner[10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        logic       exp_pre[10]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_gnt = 4'b0001 << exp_owner[i];
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_bad++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.gnt_id !== exp_owner[i]) begin n_bad++; $display("FAIL fair_id[%0d]: got %0d want %0d", i, bus.gnt_id, exp_owner[i]); end
            n_cmp++; if (bus.preempt !== exp_pre[i]) begin n_bad++; $display("FAIL fair_preempt[%0d]: got %b want %b", i, bus.preempt, exp_pre[i]); end
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 4'b0010;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL b2b_first: got %b want 0010", bus.gnt); end
        bus.req = 4'b0100;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL b2b_second: got %b want 0100", bus.gnt); end
        n_cmp++; if (bus.gnt_id !== 2'd2) begin n_bad++; $display("FAIL b2b_id: got %0d want 2", bus.gnt_id); end
        n_cmp++; if (bus.gnt_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", bus.gnt_valid); end
        n_cmp++; if (bus.preempt !== 1'b0) begin n_bad++; $display("FAIL b2b_preempt: got %b want 0", bus.preempt); end
    endtask

    task automatic test_uncontended();
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL hold_gnt[%0d]: got %b want 0100", i, bus.gnt); end
            n_cmp++; if (bus.preempt !== 1'b0) begin n_bad++; $display("FAIL hold_preempt[%0d]: got %b want 0", i, bus.preempt); end
        end
        n_cmp++; if (dut.hold_cnt_r !== 2'd2) begin n_bad++; $display("FAIL hold_sat: got %0d want 2", dut.hold_cnt_r); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b1000;
        tick();
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL mrst_pre: got %b want 1000", bus.gnt); end
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL mrst_gnt: got %b want 0000", bus.gnt); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.gnt_id !== 2'd0) begin n_bad++; $display("FAIL mrst_id: got %0d want 0", bus.gnt_id); end
        rst     = 1'b0;
        bus.req = 4'b1001;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL mrst_after: got %b want 0001", bus.gnt); end
    endtask

    task automatic test_drop_expiry();
        do_reset();
        bus.req = 4'b0011;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL dexp_first: got %b want 0001", bus.gnt); end
        tick();
        n_cmp++; if (dut.hold_cnt_r !== 2'd2) begin n_bad++; $display("FAIL dexp_hold: got %0d want 2", dut.hold_cnt_r); end
        bus.req = 4'b0010;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL dexp_gnt: got %b want 0010", bus.gnt); end
        n_cmp++; if (bus.preempt !== 1'b0) begin n_bad++; $display("FAIL dexp_preempt: got %b want 0", bus.preempt); end
        n_cmp++; if (dut.hold_cnt_r !== 2'd1) begin n_bad++; $display("FAIL dexp_hold_new: got %0d want 1", dut.hold_cnt_r); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_uncontended();
        test_mid_reset();
        test_drop_expiry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
